instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit with a 2-entry prefetch buffer.
//
// The unit keeps a fetch PC, one outstanding read to a memory port that answers
// exactly one cycle after the strobe, and a 2-entry FIFO of {pc, instr}. A new
// read is issued only when the response has a guaranteed slot, so no response
// is ever dropped. With the consumer never stalling, the unit delivers one
// instruction per cycle.
//
// Optional feature (macro FETCH_RANGE_CHK_EN): a redirect target above the
// 10-bit instruction space sets a sticky fetch_err and halts issue until reset.
// Without the macro, redirect_pc[11:10] is ignored and fetch_err is tied to 0.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   instr_addr   out  [11:0] fetch address (upper two bits always 0)
//   rd_instr_en  out  read strobe, one per request
//   instr        in   [31:0] read data, valid one cycle after rd_instr_en
//   redirect     in   single-cycle branch/jump request
//   redirect_pc  in   [11:0] redirect target
//   stall        in   consumer not ready; head entry held
//   instr_out    out  [31:0] head-of-buffer instruction
//   pc_out       out  [11:0] address of instr_out
//   instr_valid  out  instr_out/pc_out valid
//   fetch_err    out  sticky out-of-range redirect flag
module instr_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] instr_addr,
  output logic        rd_instr_en,
  input  logic [31:0] instr,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr_out,
  output logic [11:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_err
);

  logic [9:0]  pc_q, pc_d;
  logic [11:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q;
  logic [11:0] inflight_pc_q, inflight_pc_d;
  logic        halt;
  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  credit;

  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = ins0_q;
  assign pc_out      = pc0_q;
  assign pop         = instr_valid & ~stall;
  assign push        = inflight_q;

  // Slots the buffer must still provide once this cycle's pop has happened.
  assign credit = count_q + {1'b0, inflight_q} - {1'b0, pop};

  // rst gates the strobe so nothing is requested while reset is held.
  assign issue       = rst & ~redirect & ~halt & (credit <= 2'd1);
  assign rd_instr_en = issue;
  assign instr_addr  = {2'b00, pc_q};

`ifdef FETCH_RANGE_CHK_EN
  logic err_q, err_d;

  assign err_d     = err_q | (redirect & (redirect_pc[11:10] != 2'b00));
  assign halt      = err_q;
  assign fetch_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  logic unused_rpc_hi;

  assign unused_rpc_hi = ^redirect_pc[11:10];
  assign halt          = 1'b0;
  assign fetch_err     = 1'b0;
`endif

  // PC and in-flight bookkeeping.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc[9:0];
    end else if (issue) begin
      pc_d          = pc_q + 10'd1;  // wraps 0x3FF -> 0x000
      inflight_pc_d = {2'b00, pc_q};
    end
  end

  // Shift FIFO: entry 0 is always the head.
  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    if (redirect) begin
      // Flush; the response landing this cycle is dropped as well.
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d  = inflight_pc_q;
            ins0_d = instr;
          end else begin
            pc1_d  = inflight_pc_q;
            ins1_d = instr;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          ins0_d  = ins1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = inflight_pc_q;
            ins1_d = instr;
          end else begin
            pc0_d  = inflight_pc_q;
            ins0_d = instr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC[9:0];
      pc0_q         <= '0;
      ins0_q        <= '0;
      pc1_q         <= '0;
      ins1_q        <= '0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc0_q         <= pc0_d;
      ins0_q        <= ins0_d;
      pc1_q         <= pc1_d;
      ins1_q        <= ins1_d;
      count_q       <= count_d;
      inflight_q    <= issue;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized stall/redirect/reset
// traffic, checked every cycle against a queue-based model of the fetch unit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instr_addr;
  logic        rd_instr_en;
  logic [31:0] mem_instr;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        stall;
  logic [31:0] instr_out;
  logic [11:0] pc_out;
  logic        instr_valid;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [43:0] m_fifo[$];   // {pc, instr}
  bit          m_infl;
  logic [11:0] m_iaddr;
  logic [9:0]  m_pc;
  bit          m_err;

  // Outputs observed in the most recent step
  logic        obs_en, obs_valid, obs_err;
  logic [11:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;

  instr_fetch #(.RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_addr  (instr_addr),
    .rd_instr_en (rd_instr_en),
    .instr       (mem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return {8'hC3, a ^ 12'hA5A, a};
  endfunction

  // Memory answers one cycle after the strobe; otherwise drives garbage.
  always @(posedge clk) begin
    if (rd_instr_en) mem_instr <= data_of(instr_addr);
    else             mem_instr <= $urandom();
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One cycle: called at a negedge, drives inputs, checks, advances the model,
  // and returns at the next negedge.
  task automatic step(input logic s, input logic r, input logic [11:0] rp);
    bit exp_valid, pop, exp_en;
    int occ;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
    obs_en    = rd_instr_en;
    obs_addr  = instr_addr;
    obs_valid = instr_valid;
    obs_pc    = pc_out;
    obs_instr = instr_out;
    obs_err   = fetch_err;

    exp_valid = (m_fifo.size() != 0);
    pop       = exp_valid && !s;
    occ       = m_fifo.size() + int'(m_infl) - int'(pop);
    exp_en    = !r && !m_err && (occ <= 1);

    chk("rd_instr_en", rd_instr_en, exp_en);
    if (exp_en) chk("instr_addr", instr_addr, {2'b00, m_pc});
    chk("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      chk("pc_out", pc_out, m_fifo[0][43:32]);
      chk("instr_out", instr_out, m_fifo[0][31:0]);
    end
    chk("fetch_err", fetch_err, m_err);

    if (r) begin
      m_fifo.delete();
      m_infl = 0;
      m_pc   = rp[9:0];
`ifdef FETCH_RANGE_CHK_EN
      if (rp[11:10] != 2'b00) m_err = 1;
`endif
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (m_infl) m_fifo.push_back({m_iaddr, data_of(m_iaddr)});
      m_infl = exp_en;
      if (exp_en) begin
        m_iaddr = {2'b00, m_pc};
        m_pc    = 10'((int'(m_pc) + 1) % 1024);
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, and releases it at
  // a negedge so the next step is cycle 0.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_rd_en", rd_instr_en, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_fetch_err", fetch_err, 0);
    m_fifo.delete();
    m_infl   = 0;
    m_iaddr  = '0;
    m_pc     = 10'h000;
    m_err    = 0;
    stall    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int issues;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    do_reset();

    // Streaming from reset
    step(0, 0, 0); chk("c0_en", obs_en, 1); chk("c0_addr", obs_addr, 12'h000);
    step(0, 0, 0); chk("c1_valid", obs_valid, 0); chk("c1_addr", obs_addr, 12'h001);
    step(0, 0, 0); chk("c2_valid", obs_valid, 1); chk("c2_pc", obs_pc, 12'h000);
    chk("c2_instr", obs_instr, 32'hC3A5A000);
    step(0, 0, 0); chk("c3_pc", obs_pc, 12'h001);
    repeat (14) step(0, 0, 0);

    // Stall with 0x010 at the head
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("stall_pc", obs_pc, 12'h010);
      chk("stall_valid", obs_valid, 1);
      issues += int'(obs_en);
    end
    chk("stall_issue_bound", (issues <= 2), 1);
    step(0, 0, 0); chk("resume_pc0", obs_pc, 12'h010);
    step(0, 0, 0); chk("resume_pc1", obs_pc, 12'h011); chk("resume_v1", obs_valid, 1);
    step(0, 0, 0); chk("resume_pc2", obs_pc, 12'h012); chk("resume_v2", obs_valid, 1);

    // Redirect while stalled
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 12'h200);
    step(0, 0, 0); chk("r1_valid", obs_valid, 0); chk("r1_en", obs_en, 1);
    chk("r1_addr", obs_addr, 12'h200);
    step(0, 0, 0); chk("r2_valid", obs_valid, 0);
    step(0, 0, 0); chk("r3_valid", obs_valid, 1); chk("r3_pc", obs_pc, 12'h200);
    chk("r3_instr", obs_instr, 32'hC385A200);
    step(0, 0, 0); chk("r4_pc", obs_pc, 12'h201);

    // Wrap at the top of instruction space
    step(0, 1, 12'h3FE);
    step(0, 0, 0); chk("w1_addr", obs_addr, 12'h3FE);
    step(0, 0, 0); chk("w2_addr", obs_addr, 12'h3FF);
    step(0, 0, 0); chk("w3_pc", obs_pc, 12'h3FE); chk("w3_addr", obs_addr, 12'h000);
    step(0, 0, 0); chk("w4_pc", obs_pc, 12'h3FF);
    step(0, 0, 0); chk("w5_pc", obs_pc, 12'h000);

    // Fill the buffer, then reset mid-stream
    repeat (3) step(1, 0, 0);
    do_reset();
    step(0, 0, 0); chk("rs0_en", obs_en, 1); chk("rs0_addr", obs_addr, 12'h000);
    step(0, 0, 0);
    step(0, 0, 0); chk("rs2_pc", obs_pc, 12'h000); chk("rs2_valid", obs_valid, 1);

    // Out-of-range redirect
    step(0, 1, 12'h400);
    step(0, 0, 0);
`ifdef FETCH_RANGE_CHK_EN
    chk("oor_err", obs_err, 1); chk("oor_en", obs_en, 0);
    repeat (3) begin step(0, 0, 0); chk("oor_halt", obs_en, 0); end
`else
    chk("oor_err", obs_err, 0); chk("oor_en", obs_en, 1); chk("oor_addr", obs_addr, 12'h000);
`endif
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, r;
      logic [11:0] rp;
      if ($urandom_range(0, 199) == 0) do_reset();
      s  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 6);
      rp = 12'($urandom());
      if ($urandom_range(0, 99) >= 5) rp[11:10] = 2'b00;
      step(s, r, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
